// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS instruction field layout and prefetch-queue helpers
package mips_pkg;
    localparam int INSTR_W = 32;
    localparam int OPC_W   = 6;
    localparam int REG_W   = 5;
    localparam int IMM_W   = 16;
    localparam int FN_W    = 6;
    localparam int JMP_W   = 26;
    localparam int OPC_LSB = 26;
    localparam int RS_LSB  = 21;
    localparam int RT_LSB  = 16;
    localparam int RD_LSB  = 11;
    localparam int SH_LSB  = 6;
    localparam int FN_LSB  = 0;
    localparam int IMM_LSB = 0;
    localparam int JMP_LSB = 0;

    // queue depth must be a power of two so the pointers wrap for free
    function automatic bit depth_ok(input int depth);
        return depth >= 2 && (depth & (depth - 1)) == 0;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count and flush
module sync_fifo
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_flush,
    input  logic [DATA_W-1:0]      i_data,
    input  logic                   i_push,
    output logic                   o_ready,
    input  logic                   i_pop,
    output logic [DATA_W-1:0]      o_head,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_count;
    logic              w_push;
    logic              w_pop;

    assign o_ready = r_count != FULL;
    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];
    assign w_push  = i_push && o_ready;
    assign w_pop   = i_pop && r_count != '0;

    // storage needs no reset: only slots between the pointers are ever read
    always_ff @(posedge clk) begin
        if (w_push && !reset && !i_flush) r_mem[r_wptr] <= i_data;
    end

    // pointers wrap naturally at DEPTH; flush empties the queue and drops a same-edge push
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end
endmodule

// File: rtl/instr_prefetch_reg.sv
// instr_prefetch_reg: prefetch queue feeding a MIPS instruction register with field decode
module instr_prefetch_reg
    import mips_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4,
    parameter int SIGN_EXT = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_W-1:0]      instr_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   IRWrite,
    input  logic                   flush,
    output logic                   ir_valid,
    output logic                   ir_stall,
    output logic [OPC_W-1:0]       Instr_31_26,
    output logic [REG_W-1:0]       Instr_25_21,
    output logic [REG_W-1:0]       Instr_20_16,
    output logic [REG_W-1:0]       Instr_15_11,
    output logic [REG_W-1:0]       Instr_10_6,
    output logic [FN_W-1:0]        Instr_5_0,
    output logic [IMM_W-1:0]       Instr_15_0,
    output logic [JMP_W-1:0]       Instr_25_0,
    output logic [DATA_W-1:0]      imm_ext,
    output logic [$clog2(DEPTH):0] count
);
    localparam int EXT_W = DATA_W - IMM_W;

    if (DATA_W < INSTR_W) begin : g_bad_width
        $error("instr_prefetch_reg: DATA_W must be at least 32");
    end

    logic [DATA_W-1:0] r_ir;
    logic              r_ir_valid;
    logic              r_ir_stall;
    logic [DATA_W-1:0] w_head;
    logic              w_empty;
    logic              w_pop;
    logic              w_sign;

    assign w_empty = count == '0;
    assign w_pop   = IRWrite && !w_empty && !flush;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_flush (flush),
        .i_data  (instr_in),
        .i_push  (in_valid),
        .o_ready (in_ready),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (count)
    );

    // IR loads only on a successful pop; an IRWrite into an empty queue just flags a stall
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
            r_ir_stall <= 1'b0;
        end else if (flush) begin
            r_ir_valid <= 1'b0;
            r_ir_stall <= 1'b0;
        end else begin
            if (w_pop) begin
                r_ir       <= w_head;
                r_ir_valid <= 1'b1;
            end
            r_ir_stall <= IRWrite && w_empty;
        end
    end

    assign ir_valid    = r_ir_valid;
    assign ir_stall    = r_ir_stall;
    assign Instr_31_26 = r_ir[OPC_LSB +: OPC_W];
    assign Instr_25_21 = r_ir[RS_LSB +: REG_W];
    assign Instr_20_16 = r_ir[RT_LSB +: REG_W];
    assign Instr_15_11 = r_ir[RD_LSB +: REG_W];
    assign Instr_10_6  = r_ir[SH_LSB +: REG_W];
    assign Instr_5_0   = r_ir[FN_LSB +: FN_W];
    assign Instr_15_0  = r_ir[IMM_LSB +: IMM_W];
    assign Instr_25_0  = r_ir[JMP_LSB +: JMP_W];
    assign w_sign      = (SIGN_EXT != 0) && r_ir[IMM_LSB+IMM_W-1];
    assign imm_ext     = {{EXT_W{w_sign}}, r_ir[IMM_LSB +: IMM_W]};
endmodule

// File: tb/tb_instr_prefetch_reg.sv
// tb_instr_prefetch_reg: directed tests of the prefetch queue and instruction register
module tb_instr_prefetch_reg;
    logic        clk;
    logic        reset;
    logic [31:0] instr_in;
    logic        in_valid;
    logic        IRWrite;
    logic        flush;
    logic        in_ready, ir_valid, ir_stall;
    logic [5:0]  Instr_31_26, Instr_5_0;
    logic [4:0]  Instr_25_21, Instr_20_16, Instr_15_11, Instr_10_6;
    logic [15:0] Instr_15_0;
    logic [25:0] Instr_25_0;
    logic [31:0] imm_ext;
    logic [2:0]  count;
    logic        z_in_ready, z_ir_valid, z_ir_stall;
    logic [5:0]  z_31_26, z_5_0;
    logic [4:0]  z_25_21, z_20_16, z_15_11, z_10_6;
    logic [15:0] z_15_0;
    logic [25:0] z_25_0;
    logic [31:0] z_imm_ext;
    logic [2:0]  z_count;
    logic [31:0] ir;
    int          n_pass;
    int          n_total;

    assign ir = {Instr_31_26, Instr_25_0};

    instr_prefetch_reg #(.DATA_W(32), .DEPTH(4), .SIGN_EXT(1)) u_dut (
        .clk(clk), .reset(reset), .instr_in(instr_in), .in_valid(in_valid), .in_ready(in_ready),
        .IRWrite(IRWrite), .flush(flush), .ir_valid(ir_valid), .ir_stall(ir_stall),
        .Instr_31_26(Instr_31_26), .Instr_25_21(Instr_25_21), .Instr_20_16(Instr_20_16),
        .Instr_15_11(Instr_15_11), .Instr_10_6(Instr_10_6), .Instr_5_0(Instr_5_0),
        .Instr_15_0(Instr_15_0), .Instr_25_0(Instr_25_0), .imm_ext(imm_ext), .count(count)
    );

    instr_prefetch_reg #(.DATA_W(32), .DEPTH(4), .SIGN_EXT(0)) u_zx (
        .clk(clk), .reset(reset), .instr_in(instr_in), .in_valid(in_valid), .in_ready(z_in_ready),
        .IRWrite(IRWrite), .flush(flush), .ir_valid(z_ir_valid), .ir_stall(z_ir_stall),
        .Instr_31_26(z_31_26), .Instr_25_21(z_25_21), .Instr_20_16(z_20_16),
        .Instr_15_11(z_15_11), .Instr_10_6(z_10_6), .Instr_5_0(z_5_0),
        .Instr_15_0(z_15_0), .Instr_25_0(z_25_0), .imm_ext(z_imm_ext), .count(z_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        instr_in = w;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pop();
        IRWrite = 1'b1;
        step();
        IRWrite = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        n_total++; if (count !== 3'd0) $display("FAIL reset_count got %0d exp 0", count); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready); else n_pass++;
        n_total++; if (ir_valid !== 1'b0) $display("FAIL reset_ir_valid got %b exp 0", ir_valid); else n_pass++;
        n_total++; if (ir_stall !== 1'b0) $display("FAIL reset_ir_stall got %b exp 0", ir_stall); else n_pass++;
        n_total++; if (ir !== 32'h0) $display("FAIL reset_ir got %h exp 00000000", ir); else n_pass++;
        n_total++; if (imm_ext !== 32'h0) $display("FAIL reset_imm_ext got %h exp 00000000", imm_ext); else n_pass++;
    endtask

    task automatic test_decode();
        push(32'h8C220004);
        n_total++; if (count !== 3'd1) $display("FAIL decode_count_push got %0d exp 1", count); else n_pass++;
        n_total++; if (ir_valid !== 1'b0 || ir !== 32'h0) $display("FAIL decode_no_bypass got v=%b ir=%h exp v=0 ir=00000000", ir_valid, ir); else n_pass++;
        pop();
        n_total++; if (Instr_31_26 !== 6'h23) $display("FAIL decode_opcode got %h exp 23", Instr_31_26); else n_pass++;
        n_total++; if (Instr_25_21 !== 5'd1) $display("FAIL decode_rs got %0d exp 1", Instr_25_21); else n_pass++;
        n_total++; if (Instr_20_16 !== 5'd2) $display("FAIL decode_rt got %0d exp 2", Instr_20_16); else n_pass++;
        n_total++; if (imm_ext !== 32'h00000004) $display("FAIL decode_imm_ext got %h exp 00000004", imm_ext); else n_pass++;
        n_total++; if (Instr_25_0 !== 26'h0220004) $display("FAIL decode_target got %h exp 0220004", Instr_25_0); else n_pass++;
        n_total++; if (ir_valid !== 1'b1) $display("FAIL decode_ir_valid got %b exp 1", ir_valid); else n_pass++;
        n_total++; if (count !== 3'd0) $display("FAIL decode_count_pop got %0d exp 0", count); else n_pass++;
    endtask

    task automatic test_sign_ext();
        push(32'h2021FFFF);
        pop();
        n_total++; if (Instr_15_0 !== 16'hFFFF) $display("FAIL sext_imm got %h exp ffff", Instr_15_0); else n_pass++;
        n_total++; if (imm_ext !== 32'hFFFFFFFF) $display("FAIL sext_imm_ext got %h exp ffffffff", imm_ext); else n_pass++;
        n_total++; if (z_imm_ext !== 32'h0000FFFF) $display("FAIL zext_imm_ext got %h exp 0000ffff", z_imm_ext); else n_pass++;
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) push(32'hA0000001 + i);
        n_total++; if (count !== 3'd4) $display("FAIL full_count got %0d exp 4", count); else n_pass++;
        n_total++; if (in_ready !== 1'b0) $display("FAIL full_in_ready got %b exp 0", in_ready); else n_pass++;
        push(32'hDEADBEEF);
        n_total++; if (count !== 3'd4) $display("FAIL full_fifth_push got %0d exp 4", count); else n_pass++;
        instr_in = 32'hBADBAD00;
        in_valid = 1'b1;
        IRWrite = 1'b1;
        step();
        in_valid = 1'b0;
        IRWrite = 1'b0;
        n_total++; if (count !== 3'd3) $display("FAIL full_pop_blocks_push got %0d exp 3", count); else n_pass++;
        n_total++; if (ir !== 32'hA0000001) $display("FAIL full_order_0 got %h exp a0000001", ir); else n_pass++;
        for (int i = 1; i < 4; i++) begin
            pop();
            n_total++; if (ir !== 32'hA0000001 + i) $display("FAIL full_order_%0d got %h exp %h", i, ir, 32'hA0000001 + i); else n_pass++;
        end
        n_total++; if (count !== 3'd0 || in_ready !== 1'b1) $display("FAIL full_drained got count=%0d rdy=%b exp count=0 rdy=1", count, in_ready); else n_pass++;
    endtask

    task automatic test_stall();
        push(32'h00851020);
        pop();
        n_total++; if (Instr_20_16 !== 5'd5 || Instr_15_11 !== 5'd2 || Instr_10_6 !== 5'd0 || Instr_5_0 !== 6'h20)
            $display("FAIL stall_fields got rt=%0d rd=%0d sh=%0d fn=%h exp rt=5 rd=2 sh=0 fn=20", Instr_20_16, Instr_15_11, Instr_10_6, Instr_5_0); else n_pass++;
        n_total++; if (ir_stall !== 1'b0) $display("FAIL stall_before got %b exp 0", ir_stall); else n_pass++;
        pop();
        n_total++; if (ir_stall !== 1'b1) $display("FAIL stall_set got %b exp 1", ir_stall); else n_pass++;
        n_total++; if (ir !== 32'h00851020) $display("FAIL stall_ir_held got %h exp 00851020", ir); else n_pass++;
        n_total++; if (ir_valid !== 1'b1) $display("FAIL stall_ir_valid got %b exp 1", ir_valid); else n_pass++;
        step();
        n_total++; if (ir_stall !== 1'b0) $display("FAIL stall_one_cycle got %b exp 0", ir_stall); else n_pass++;
    endtask

    task automatic test_flush();
        push(32'h11111111);
        push(32'h22222222);
        n_total++; if (count !== 3'd2) $display("FAIL flush_pre_count got %0d exp 2", count); else n_pass++;
        instr_in = 32'h33333333;
        in_valid = 1'b1;
        IRWrite = 1'b1;
        flush = 1'b1;
        step();
        IRWrite = 1'b0;
        flush = 1'b0;
        n_total++; if (count !== 3'd0) $display("FAIL flush_count got %0d exp 0", count); else n_pass++;
        n_total++; if (ir_valid !== 1'b0) $display("FAIL flush_ir_valid got %b exp 0", ir_valid); else n_pass++;
        n_total++; if (ir_stall !== 1'b0) $display("FAIL flush_ir_stall got %b exp 0", ir_stall); else n_pass++;
        push(32'hCAFEF00D);
        n_total++; if (count !== 3'd1) $display("FAIL flush_next_push got %0d exp 1", count); else n_pass++;
        pop();
        n_total++; if (ir !== 32'hCAFEF00D) $display("FAIL flush_word_lost got %h exp cafef00d", ir); else n_pass++;
    endtask

    task automatic test_back_to_back();
        push(32'h50000000);
        for (int i = 1; i <= 10; i++) begin
            instr_in = 32'h50000000 + i;
            in_valid = 1'b1;
            IRWrite = 1'b1;
            step();
            n_total++; if (ir !== 32'h50000000 + i - 1 || count !== 3'd1)
                $display("FAIL wrap_pair_%0d got ir=%h count=%0d exp ir=%h count=1", i, ir, count, 32'h50000000 + i - 1); else n_pass++;
        end
        in_valid = 1'b0;
        IRWrite = 1'b0;
        pop();
        n_total++; if (ir !== 32'h5000000A) $display("FAIL wrap_last got %h exp 5000000a", ir); else n_pass++;
        push(32'h77777777);
        push(32'h88888888);
        reset = 1'b1;
        instr_in = 32'h99999999;
        in_valid = 1'b1;
        IRWrite = 1'b1;
        step();
        reset = 1'b0;
        in_valid = 1'b0;
        IRWrite = 1'b0;
        n_total++; if (count !== 3'd0) $display("FAIL midreset_count got %0d exp 0", count); else n_pass++;
        n_total++; if (ir !== 32'h0 || imm_ext !== 32'h0 || Instr_20_16 !== 5'd0 || Instr_15_11 !== 5'd0)
            $display("FAIL midreset_fields got ir=%h imm=%h exp 0", ir, imm_ext); else n_pass++;
        n_total++; if (ir_valid !== 1'b0 || ir_stall !== 1'b0) $display("FAIL midreset_flags got v=%b s=%b exp 0 0", ir_valid, ir_stall); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL midreset_in_ready got %b exp 1", in_ready); else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        reset = 1'b1;
        instr_in = '0;
        in_valid = 1'b0;
        IRWrite = 1'b0;
        flush = 1'b0;
        test_reset();
        test_decode();
        test_sign_ext();
        test_full();
        test_stall();
        test_flush();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/instr_prefetch_reg.md
INSTR_PREFETCH_REG -- requirements
Module: instr_prefetch_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning instruction word width; legal range 32 and up.
REQ-002 SHALL have parameter DEPTH, default 4, meaning prefetch queue entries; power of two, at least 2.
REQ-003 SHALL have parameter SIGN_EXT, default 1, meaning imm_ext mode: 1 sign-extends, 0 zero-extends.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising-edge clock) and reset input 1 (synchronous, active-high).
REQ-005 SHALL have instr_in, input, DATA_W, fetched word from memory.
REQ-006 SHALL have in_valid, input, 1, instr_in is valid this cycle.
REQ-007 SHALL have in_ready, output, 1, queue can accept a word.
REQ-008 SHALL have IRWrite, input, 1, request to load the IR from the queue head.
REQ-009 SHALL have flush, input, 1, discard all queued words and invalidate the IR.
REQ-010 SHALL have ir_valid, output, 1, IR holds a live instruction.
REQ-011 SHALL have ir_stall, output, 1, the last IRWrite found the queue empty.
REQ-012 SHALL have Instr_31_26, output, 6, opcode.
REQ-013 SHALL have Instr_25_21 and Instr_20_16, output, 5 each, rs and rt.
REQ-014 SHALL have Instr_15_11, output, 5, rd.
REQ-015 SHALL have Instr_10_6, output, 5, shamt.
REQ-016 SHALL have Instr_5_0, output, 6, funct.
REQ-017 SHALL have Instr_15_0, output, 16, immediate.
REQ-018 SHALL have Instr_25_0, output, 26, jump target.
REQ-019 SHALL have imm_ext, output, DATA_W, Instr_15_0 extended per SIGN_EXT.
REQ-020 SHALL have count, output, clog2(DEPTH)+1, queue occupancy.

Function
REQ-021 SHALL push instr_in on a rising clk edge when in_valid and in_ready are both high; in_ready SHALL equal (count != DEPTH).
REQ-022 SHALL pop the queue head into the IR register on an edge where IRWrite is high and count > 0, and SHALL set ir_valid on that edge.
REQ-023 SHALL keep the IR and ir_valid unchanged, and SHALL set ir_stall for one cycle, on an edge where IRWrite is high and count == 0; there SHALL be no bypass from instr_in to the IR.
REQ-024 SHALL hold the IR in all cycles without a successful pop.
REQ-025 SHALL drive all field outputs and imm_ext combinationally from the IR register, so a push at edge N can reach the fields no earlier than edge N+1.
REQ-026 SHALL keep count unchanged when a push and a pop occur on the same edge with 0 < count < DEPTH.
REQ-027 SHALL block a push when count == DEPTH, even if a pop occurs on the same edge, because in_ready is low.
REQ-028 SHALL wrap the read and write pointers modulo DEPTH, with no word lost or duplicated across the wrap.
REQ-029 SHALL give flush priority over push and pop: count becomes 0, ir_valid becomes 0, ir_stall becomes 0, IR contents are don't-care, and the same-edge push is dropped.
REQ-030 SHALL allow a push on the edge immediately after flush deasserts.

Reset
REQ-031 SHALL, while reset is high on an edge, clear count, the pointers, ir_valid and ir_stall, clear the IR to all-zero (so every field output and imm_ext read 0), and hold in_ready at 1 from the following cycle.
REQ-032 SHALL give reset priority over flush, push and IRWrite, and SHALL abort any in-progress transfer with no partial state retained.

Structure
REQ-033 SHALL take the field bit positions, the OPC_W=6, REG_W=5 and IMM_W=16 constants, and the DEPTH legality check from the shared mips_pkg package.
REQ-034 SHALL instantiate one sub-module, sync_fifo (parameters DATA_W and DEPTH), containing storage, pointers and count; the IR and field decode SHALL sit in the top module.

Verification
REQ-035 Scenario: after reset, push 0x8C220004 then IRWrite -> Instr_31_26=0x23, Instr_25_21=1, Instr_20_16=2, imm_ext=0x00000004, ir_valid=1.
REQ-036 Scenario: push 0x2021FFFF with SIGN_EXT=1 and again with SIGN_EXT=0 -> imm_ext is 0xFFFFFFFF and then 0x0000FFFF.
REQ-037 Scenario: DEPTH=4, push 4 words without IRWrite -> count=4 and in_ready=0; a 5th in_valid is not accepted; 4 IRWrites then return the words in order.
REQ-038 Scenario: IRWrite with an empty queue while IR=0x00851020 -> ir_stall=1 for one cycle and the IR is unchanged.
REQ-039 Scenario: count=2 with push, pop and flush all high on one edge -> count=0, ir_valid=0, and the pushed word is lost.
REQ-040 Scenario: run 10 push/pop pairs through DEPTH=4 -> order is preserved across the pointer wrap; then assert reset mid-stream -> all outputs 0 and count=0 on the next cycle.
